// File: rtl/snn_seq_ctrl_if.sv
// Bus bundle between the SNN sequencer and its UART, input RAM and core neighbours.
// Latency: none, signal grouping only.
// Backpressure: carried by tx_rdy (uart_tx idle) and core_done; rx bytes have none.
interface snn_seq_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              rx_rdy;
  logic [7:0]        rx_data;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_d;
  logic              core_start;
  logic [ADDR_W-1:0] core_addr;
  logic              core_done;
  logic [3:0]        digit;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_rdy;

  // Sequencer side.
  modport master (
    input  rx_rdy, rx_data, core_addr, core_done, digit, tx_rdy,
    output ram_we, ram_addr, ram_d, core_start, tx_start, tx_data
  );

  // Surrounding blocks (uart_rx/uart_tx, ram_input_unit, snn_core).
  modport slave (
    output rx_rdy, rx_data, core_addr, core_done, digit, tx_rdy,
    input  ram_we, ram_addr, ram_d, core_start, tx_start, tx_data
  );
endinterface

// File: rtl/snn_seq_ctrl.sv
// Frame sequencer: unpacks UART bytes into 1-bit RAM writes, runs snn_core, returns ASCII digit.
// Latency: byte captured at cycle N is written at N+1..N+8; core_start one cycle after last write.
// Backpressure: 1-deep pending byte while writing, overflow dropped (led[6]); tx waits on tx_rdy.
// Optional core watchdog enabled by defining SNN_TIMEOUT_EN (limit TIMEOUT_CYCLES).
module snn_seq_ctrl #(
  parameter int NUM_BYTES      = 98,
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  snn_seq_ctrl_if.master        bus,
  output logic [7:0]            led,
  output logic                  busy
);

  localparam int BC_W = $clog2(NUM_BYTES);

  typedef enum logic [2:0] {
    S_RECV, S_WRITE, S_START, S_COMPUTE, S_SEND, S_WAIT_LO, S_WAIT_HI
  } state_t;

  state_t          state, state_nxt;
  logic [7:0]      sh;
  logic [2:0]      bit_cnt;
  logic [BC_W-1:0] byte_cnt;
  logic            pend_vld;
  logic [7:0]      pend_dat;
  logic [3:0]      dig_q;
  logic            ovr_q;
  logic            err_q;
  logic [7:0]      tx_dat_q;
  logic            last_bit;
  logic            last_byte;
  logic            timeout;

  assign last_bit  = (bit_cnt == 3'd7);
  assign last_byte = (byte_cnt == BC_W'(NUM_BYTES - 1));

`ifdef SNN_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  // Watchdog: counts cycles spent in COMPUTE, cleared in every other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 to_cnt <= '0;
    else if (state == S_COMPUTE) to_cnt <= to_cnt + TO_W'(1);
    else                        to_cnt <= '0;
  end

  assign timeout = (state == S_COMPUTE) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RECV;
    else        state <= state_nxt;
  end

  // Next-state logic; a byte waiting (pending or arriving on bit 7) keeps WRITE going with no gap.
  always_comb begin
    state_nxt = state;
    case (state)
      S_RECV:    if (bus.rx_rdy) state_nxt = S_WRITE;
      S_WRITE: begin
        if (last_bit) begin
          if (last_byte)                     state_nxt = S_START;
          else if (!pend_vld && !bus.rx_rdy) state_nxt = S_RECV;
        end
      end
      S_START:   state_nxt = S_COMPUTE;
      S_COMPUTE: if (bus.core_done || timeout) state_nxt = S_SEND;
      S_SEND:    if (bus.tx_rdy) state_nxt = S_WAIT_LO;
      S_WAIT_LO: if (!bus.tx_rdy) state_nxt = S_WAIT_HI;
      S_WAIT_HI: if (bus.tx_rdy) state_nxt = S_RECV;
      default:   state_nxt = S_RECV;
    endcase
  end

  // Outputs: RAM address belongs to the core only while it computes.
  always_comb begin
    bus.ram_we     = 1'b0;
    bus.ram_d      = 1'b0;
    bus.ram_addr   = '0;
    bus.core_start = 1'b0;
    bus.tx_start   = 1'b0;
    case (state)
      S_WRITE: begin
        bus.ram_we   = 1'b1;
        bus.ram_d    = sh[bit_cnt];
        bus.ram_addr = ADDR_W'({byte_cnt, bit_cnt});
      end
      S_START:   bus.core_start = 1'b1;
      S_COMPUTE: bus.ram_addr   = bus.core_addr;
      S_SEND:    bus.tx_start   = bus.tx_rdy;
      default: ;
    endcase
  end

  // Datapath: byte capture, pending slot, counters, result and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh       <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      pend_vld <= 1'b0;
      pend_dat <= '0;
      dig_q    <= '0;
      ovr_q    <= 1'b0;
      err_q    <= 1'b0;
      tx_dat_q <= '0;
    end else begin
      case (state)
        S_RECV: begin
          if (bus.rx_rdy) begin
            sh      <= bus.rx_data;
            bit_cnt <= '0;
          end
        end
        S_WRITE: begin
          bit_cnt <= bit_cnt + 3'd1;  // wraps to 0 after bit 7
          if (last_bit) begin
            if (last_byte) begin
              // Anything queued behind the final byte is surplus to this frame.
              byte_cnt <= '0;
              pend_vld <= 1'b0;
              if (pend_vld || bus.rx_rdy) ovr_q <= 1'b1;
            end else begin
              byte_cnt <= byte_cnt + BC_W'(1);
              if (pend_vld) begin
                // Pending slot frees this cycle, so an arriving byte takes it.
                sh       <= pend_dat;
                pend_vld <= bus.rx_rdy;
                if (bus.rx_rdy) pend_dat <= bus.rx_data;
              end else if (bus.rx_rdy) begin
                sh <= bus.rx_data;
              end
            end
          end else if (bus.rx_rdy) begin
            if (pend_vld) begin
              ovr_q <= 1'b1;
            end else begin
              pend_vld <= 1'b1;
              pend_dat <= bus.rx_data;
            end
          end
        end
        S_COMPUTE: begin
          if (bus.rx_rdy) ovr_q <= 1'b1;
          if (bus.core_done) begin
            dig_q <= bus.digit;
            if (bus.digit > 4'd9) begin
              tx_dat_q <= 8'h3F;
              err_q    <= 1'b1;
            end else begin
              tx_dat_q <= 8'h30 + {4'h0, bus.digit};
            end
          end else if (timeout) begin
            tx_dat_q <= 8'h3F;
            err_q    <= 1'b1;
          end
        end
        default: if (bus.rx_rdy) ovr_q <= 1'b1;
      endcase
    end
  end

  assign bus.tx_data = tx_dat_q;
  assign led         = {err_q, ovr_q, 2'b00, dig_q};
  assign busy        = (state != S_RECV);

endmodule

// File: tb/tb_snn_seq_ctrl.sv
// Bench for snn_seq_ctrl: random frames against a byte-level acceptance/timing model.
// Latency: expected write cycles derived from arrival times and an 8-cycle writer.
// Backpressure: models the 1-deep pending slot and a uart_tx that goes busy after each start.
module tb_snn_seq_ctrl;
  localparam int NUM_BYTES = 98;
  localparam int ADDR_W    = 10;
  localparam int NPIX      = NUM_BYTES * 8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] led;
  logic       busy;

  snn_seq_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  snn_seq_ctrl #(
    .NUM_BYTES(NUM_BYTES), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master), .led(led), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int addr; logic d; int cyc; } wr_t;
  wr_t        wr_q[$];
  logic [7:0] tx_q[$];
  logic       img_exp [NPIX];
  logic       img_dut [NPIX];

  int n_chk = 0, n_pass = 0;
  logic       exp_ovr = 1'b0, exp_err = 1'b0;
  logic [3:0] exp_dig = 4'd0;
  int acc_cnt = 0, last_start = -100, exp_start_cyc = -1, start_cnt = 0, last_tx_cyc = -1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_images();
    for (int i = 0; i < NPIX; i++) begin
      img_exp[i] = 1'b0;
      img_dut[i] = 1'b0;
    end
  endtask

  // Reference: a byte is kept if the frame still needs bytes and the single waiting slot is free;
  // kept bytes are written 8 cycles each, back to back, starting the cycle after arrival.
  task automatic send_byte(input logic [7:0] b);
    int t, st;
    t = cyc;
    if (acc_cnt >= NUM_BYTES || last_start > t + 1) begin
      exp_ovr = 1'b1;
    end else begin
      st = (last_start + 8 > t + 1) ? last_start + 8 : t + 1;
      for (int i = 0; i < 8; i++) begin
        wr_t e;
        e.addr = acc_cnt * 8 + i;
        e.d    = b[i];
        e.cyc  = st + i;
        wr_q.push_back(e);
        img_exp[acc_cnt * 8 + i] = b[i];
      end
      last_start = st;
      acc_cnt++;
      if (acc_cnt == NUM_BYTES) exp_start_cyc = st + 8;
    end
    bus.rx_data = b;
    bus.rx_rdy  = 1'b1;
    @(negedge clk);
    bus.rx_rdy  = 1'b0;
  endtask

  task automatic fill_frame(input int gmin, input int gmax, input int pat);
    while (acc_cnt < NUM_BYTES) begin
      send_byte(pat < 0 ? 8'($urandom) : 8'(pat));
      idle($urandom_range(gmax, gmin) - 1);
    end
  endtask

  task automatic wait_start();
    int k = 0;
    while (start_cnt == 0 && k < 3000) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (start_cnt == 0) begin
      n_chk++;
      $display("FAIL core_start_wait: no pulse within %0d cycles", k);
    end
    for (int i = 0; i < 4; i++) begin
      bus.core_addr = ADDR_W'($urandom);
      @(negedge clk);
      chk("compute_ram_addr", bus.ram_addr, bus.core_addr);
      chk("compute_ram_we", bus.ram_we, 0);
      #1;
    end
  endtask

  task automatic end_frame();
    int k = 0, nbad = 0;
    while (busy && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      n_chk++;
      $display("FAIL busy_drop_wait: still busy after %0d cycles", k);
    end
    chk("led", led, {exp_err, exp_ovr, 2'b00, exp_dig});
    chk("core_start_count", start_cnt, 1);
    chk("writes_outstanding", wr_q.size(), 0);
    chk("tx_outstanding", tx_q.size(), 0);
    for (int i = 0; i < NPIX; i++) if (img_dut[i] !== img_exp[i]) nbad++;
    chk("ram_image_mismatches", nbad, 0);
    acc_cnt = 0;
    start_cnt = 0;
    exp_start_cyc = -1;
  endtask

  task automatic finish_frame(input logic [3:0] d, input bit drop);
    wait_start();
    if (drop) send_byte(8'($urandom));
    tx_q.push_back(d <= 4'd9 ? 8'h30 + {4'h0, d} : 8'h3F);
    exp_dig = d;
    if (d > 4'd9) exp_err = 1'b1;
    bus.digit     = d;
    bus.core_done = 1'b1;
    @(negedge clk);
    bus.core_done = 1'b0;
    bus.digit     = 4'($urandom);
    end_frame();
  endtask

`ifdef SNN_TIMEOUT_EN
  task automatic finish_timeout();
    int entry;
    wait_start();
    entry = exp_start_cyc + 1;
    tx_q.push_back(8'h3F);
    exp_err = 1'b1;
    end_frame();
    chk("timeout_tx_cycle", last_tx_cyc, entry + 100);
  endtask
`endif

  task automatic check_reset();
    chk("rst_led", led, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ram_we", bus.ram_we, 0);
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_core_start", bus.core_start, 0);
    chk("rst_tx_start", bus.tx_start, 0);
    chk("rst_tx_data", bus.tx_data, 0);
  endtask

  // Monitor: every DUT output event is matched against the scoreboard queues.
  always @(negedge clk) begin
    wr_t e;
    int  a;
    if (rst_n) begin
      if (bus.ram_we) begin
        a = int'(bus.ram_addr);
        if (wr_q.size() == 0) begin
          chk("unexpected_write_addr", a, -1);
        end else begin
          e = wr_q.pop_front();
          chk("wr_addr", a, e.addr);
          chk("wr_bit", bus.ram_d, e.d);
          chk("wr_cycle", cyc, e.cyc);
        end
        if (a < NPIX) img_dut[a] = bus.ram_d;
      end
      if (bus.core_start) begin
        start_cnt++;
        chk("core_start_cycle", cyc, exp_start_cyc);
      end
      if (bus.tx_start) begin
        last_tx_cyc = cyc;
        if (tx_q.size() == 0) chk("unexpected_tx_data", bus.tx_data, -1);
        else                  chk("tx_data", bus.tx_data, tx_q.pop_front());
      end
    end
  end

  // uart_tx model: goes busy the cycle after a start, idles again a few cycles later.
  always begin
    @(negedge clk);
    if (rst_n && bus.tx_start) begin
      @(negedge clk);
      bus.tx_rdy = 1'b0;
      repeat (3) @(negedge clk);
      bus.tx_rdy = 1'b1;
      chk("busy_before_tx_idle", busy, 1);
      @(negedge clk);
      chk("busy_after_tx_idle", busy, 0);
    end
  end

  initial begin
    #1_000_000;
    n_chk++;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bus.rx_rdy    = 1'b0;
    bus.rx_data   = 8'h00;
    bus.core_addr = '0;
    bus.core_done = 1'b0;
    bus.digit     = 4'd0;
    bus.tx_rdy    = 1'b1;
    clear_images();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset();
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Frame of 0x01 bytes, 20 cycles apart, digit 7.
    fill_frame(20, 20, 1);
    finish_frame(4'd7, 1'b0);

    // Two bytes 3 cycles apart go through the pending slot without overrun.
    send_byte(8'($urandom));
    idle(2);
    send_byte(8'($urandom));
    idle(20);
    chk("pending_no_overrun", led[6], 0);
    fill_frame(9, 25, -1);
    finish_frame(4'($urandom_range(9, 0)), 1'b0);

    // Three bytes within 8 cycles overrun; extra byte during COMPUTE; out-of-range digit.
    send_byte(8'($urandom));
    idle(2);
    send_byte(8'($urandom));
    idle(2);
    send_byte(8'($urandom));
    idle(15);
    chk("triple_overrun", led[6], 1);
    fill_frame(1, 12, -1);
    finish_frame(4'd12, 1'b1);

    // Reset after 40 bytes, then a full frame from address 0.
    for (int i = 0; i < 40; i++) begin
      send_byte(8'($urandom));
      idle($urandom_range(12, 1) - 1);
    end
    #2 rst_n = 1'b0;
    wr_q.delete();
    tx_q.delete();
    acc_cnt = 0;
    last_start = -100;
    exp_start_cyc = -1;
    start_cnt = 0;
    exp_ovr = 1'b0;
    exp_err = 1'b0;
    exp_dig = 4'd0;
    clear_images();
    @(negedge clk);
    check_reset();
    #2 rst_n = 1'b1;
    @(negedge clk);
    fill_frame(1, 10, -1);
    finish_frame(4'($urandom), 1'b0);

`ifdef SNN_TIMEOUT_EN
    fill_frame(1, 10, -1);
    finish_timeout();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
